// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32-entry, two-read/one-write register file for the single-cycle
// datapath. Reads are combinational with optional same-cycle write forwarding.
// Each entry carries a "written since reset" flag, and a saturating counter
// tracks committed writes. x0 is hard-wired to zero.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_we,
  input  logic [DATA_W-1:0] rd_wdata,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_uninit,
  output logic              rs2_uninit,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;

  // A write only takes effect for a non-zero destination.
  logic wr_commit;
  assign wr_commit = rd_we && (rd_addr != '0);

  // Next-state for every entry; x0 never holds anything but zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign regs_d[gi]  = '0;
        assign valid_d[gi] = 1'b1;
      end else begin : g_reg
        assign regs_d[gi]  = (wr_commit && (rd_addr == ADDR_W'(gi))) ? rd_wdata : regs_q[gi];
        assign valid_d[gi] = valid_q[gi] | (wr_commit && (rd_addr == ADDR_W'(gi)));
      end
    end
  endgenerate

  // Counter of committed writes, holding at all-ones instead of wrapping.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit && (wr_count_q != {CNT_W{1'b1}})) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // Storage, valid flags and counter; reset clears everything without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      valid_q    <= DEPTH'(1);
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      valid_q    <= valid_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  // Both read ports share one description so they resolve identically.
  logic [ADDR_W-1:0] rs_addr   [2];
  logic [DATA_W-1:0] rs_data   [2];
  logic              rs_uninit [2];

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic hit;
      assign hit = wr_commit && (rd_addr == rs_addr[gi]);

      // Combinational read with optional forwarding of the in-flight write; forced to zero in reset.
      always_comb begin
        rs_data[gi]   = '0;
        rs_uninit[gi] = 1'b0;
        if (rst && (rs_addr[gi] != '0)) begin
          if ((BYPASS != 0) && hit) begin
            rs_data[gi] = rd_wdata;
          end else begin
            rs_data[gi]   = regs_q[rs_addr[gi]];
            rs_uninit[gi] = ~valid_q[rs_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign rs1_data   = rs_data[0];
  assign rs2_data   = rs_data[1];
  assign rs1_uninit = rs_uninit[0];
  assign rs2_uninit = rs_uninit[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: drives three register-file instances (forwarding on,
// forwarding off, 2-bit counter) from shared stimulus and compares them every
// cycle against an array-based model, plus literal spot checks.
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we;
  logic [31:0] rd_wdata;

  logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data, c_rs1_data, c_rs2_data;
  logic        b_rs1_un, b_rs2_un, n_rs1_un, n_rs2_un, c_rs1_un, c_rs2_un;
  logic [15:0] b_cnt, n_cnt;
  logic [1:0]  c_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Behavioural model
  logic [31:0] mem [32];
  bit          val [32];
  int          nwr;

  reg_file_2r1w #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_wdata(rd_wdata), .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_uninit(b_rs1_un), .rs2_uninit(b_rs2_un), .wr_count(b_cnt));

  reg_file_2r1w #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_wdata(rd_wdata), .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
    .rs1_uninit(n_rs1_un), .rs2_uninit(n_rs2_un), .wr_count(n_cnt));

  reg_file_2r1w #(.BYPASS(1), .CNT_W(2)) u_cnt (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_wdata(rd_wdata), .rs1_data(c_rs1_data), .rs2_data(c_rs2_data),
    .rs1_uninit(c_rs1_un), .rs2_uninit(c_rs2_un), .wr_count(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state update: async clear, otherwise commit non-zero writes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = 32'h0;
        val[i] = (i == 0);
      end
      nwr = 0;
    end else if (rd_we && rd_addr != 5'd0) begin
      mem[rd_addr] = rd_wdata;
      val[rd_addr] = 1'b1;
      nwr = nwr + 1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 32'h0;
    if (byp && rd_we && rd_addr == a) return rd_wdata;
    return mem[a];
  endfunction

  function automatic logic [31:0] exp_un(input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 32'h0;
    if (byp && rd_we && rd_addr == a) return 32'h0;
    return val[a] ? 32'h0 : 32'h1;
  endfunction

  function automatic logic [31:0] sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("byp_rs1_data", b_rs1_data, exp_data(rs1_addr, 1));
      check("byp_rs2_data", b_rs2_data, exp_data(rs2_addr, 1));
      check("byp_rs1_un", 32'(b_rs1_un), exp_un(rs1_addr, 1));
      check("byp_rs2_un", 32'(b_rs2_un), exp_un(rs2_addr, 1));
      check("byp_cnt", 32'(b_cnt), sat(nwr, 65535));
      check("nob_rs1_data", n_rs1_data, exp_data(rs1_addr, 0));
      check("nob_rs2_data", n_rs2_data, exp_data(rs2_addr, 0));
      check("nob_rs1_un", 32'(n_rs1_un), exp_un(rs1_addr, 0));
      check("nob_rs2_un", 32'(n_rs2_un), exp_un(rs2_addr, 0));
      check("nob_cnt", 32'(n_cnt), sat(nwr, 65535));
      check("cnt_rs1_data", c_rs1_data, exp_data(rs1_addr, 1));
      check("cnt_rs2_un", 32'(c_rs2_un), exp_un(rs2_addr, 1));
      check("cnt_cnt", 32'(c_cnt), sat(nwr, 3));
    end
  end

  // One write/read transaction, held across a single rising edge.
  task automatic txn(input bit we, input logic [4:0] rd, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2);
    rd_we = we; rd_addr = rd; rd_wdata = wd; rs1_addr = r1; rs2_addr = r2;
    $display("txn rst=%0b we=%0b rd=x%0d wdata=%h rs1=x%0d rs2=x%0d", rst, we, rd, wd, r1, r2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; rd_we = 0; rd_addr = 0; rd_wdata = 0; rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int cnt_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b0; rd_we = 0; rd_addr = 0; rd_wdata = 0; rs1_addr = 0; rs2_addr = 0;
    #1 cmp_en = 1;
    do_reset();

    // Post-reset sweep of all addresses on both ports.
    check("rst_cnt", 32'(b_cnt), 32'h0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      check("rst_rs1_data", b_rs1_data, 32'h0);
      check("rst_rs2_data", b_rs2_data, 32'h0);
      check("rst_rs1_un", 32'(b_rs1_un), (a != 0) ? 32'h1 : 32'h0);
      check("rst_rs2_un", 32'(b_rs2_un), (a != 31) ? 32'h1 : 32'h0);
    end

    // x5/x6 writes on consecutive edges.
    @(posedge clk); #1;
    txn(1, 5'd5, 32'hDEADBEEF, 0, 0);
    txn(1, 5'd6, 32'h00000010, 0, 0);
    rd_we = 0; rs1_addr = 5; rs2_addr = 6; #2;
    check("x5_data", b_rs1_data, 32'hDEADBEEF);
    check("x6_data", b_rs2_data, 32'h00000010);
    check("x5_un", 32'(b_rs1_un), 32'h0);
    check("x6_un", 32'(b_rs2_un), 32'h0);
    check("x56_cnt", 32'(b_cnt), 32'd2);

    // Writes to x0 are discarded.
    txn(1, 5'd0, 32'hFFFFFFFF, 0, 0);
    rd_we = 0; #2;
    check("x0_data", b_rs1_data, 32'h0);
    check("x0_un", 32'(b_rs1_un), 32'h0);
    check("x0_cnt", 32'(b_cnt), 32'd2);

    // Same-cycle forwarding versus stored-value reads on never-written x7.
    do_reset();
    rd_we = 1; rd_addr = 7; rd_wdata = 32'h12345678; rs1_addr = 7; rs2_addr = 7;
    #2;
    check("byp_x7_rs1", b_rs1_data, 32'h12345678);
    check("byp_x7_rs2", b_rs2_data, 32'h12345678);
    check("byp_x7_un", 32'(b_rs1_un | b_rs2_un), 32'h0);
    check("nob_x7_rs1", n_rs1_data, 32'h0);
    check("nob_x7_rs2", n_rs2_data, 32'h0);
    check("nob_x7_un", 32'({n_rs1_un, n_rs2_un}), 32'h3);
    @(posedge clk); #1;
    rd_we = 0; #1;
    check("nob_x7_post", n_rs1_data, 32'h12345678);
    check("nob_x7_post_un", 32'(n_rs2_un), 32'h0);

    // Saturation of the 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      txn(1, 5'(i + 1), 32'(i * 3 + 1), 0, 0);
      check("cnt2_seq", 32'(c_cnt), 32'(cnt_exp[i]));
    end

    // Asynchronous reset between edges wipes a completed write.
    do_reset();
    txn(1, 5'd3, 32'hA5A5A5A5, 3, 3);
    rd_we = 0; #2;
    check("pre_rst_x3", b_rs1_data, 32'hA5A5A5A5);
    rd_we = 1; rd_addr = 3; rd_wdata = 32'h11111111;
    rst = 1'b0; #1;
    check("mid_rst_x3", b_rs1_data, 32'h0);
    check("mid_rst_un", 32'(b_rs1_un), 32'h0);
    @(posedge clk); #1;
    rd_we = 0; rst = 1'b1; #1;
    check("post_rst_x3", b_rs1_data, 32'h0);
    check("post_rst_un", 32'(b_rs1_un), 32'h1);
    check("post_rst_cnt", 32'(b_cnt), 32'h0);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      logic [4:0] rd, r1, r2;
      rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 79) == 0) rst = 1'b0;
      else rst = 1'b1;
      txn(1'($urandom_range(0, 1)), rd, $urandom, r1, r2);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the ALU: rs1_data drives alu_src1; rs2_data drives the register input of the ALU operand-2 mux.
- Written once per cycle by the write-back path.
- Tracks per-register "written since reset" state and a committed-write counter, used by verification and debug.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the stored value only.
- CNT_W, 16, width of the write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rd_addr  input  ADDR_W  write address.
- rd_we  input  1  write enable.
- rd_wdata  input  DATA_W  write data.
- rs1_data  output  DATA_W  read port 1 data (combinational).
- rs2_data  output  DATA_W  read port 2 data (combinational).
- rs1_uninit  output  1  rs1 targets a register not written since reset.
- rs2_uninit  output  1  rs2 targets a register not written since reset.
- wr_count  output  CNT_W  count of committed writes since reset.

Behaviour:
- Reset (rst=0), asynchronous, takes effect without a clock edge:
  - all registers cleared to 0.
  - valid vector cleared, except entry 0, which is always valid.
  - wr_count = 0.
  - rs1_data and rs2_data forced to 0.
  - rs1_uninit and rs2_uninit forced to 0.
- Reset release is synchronous to clk: the first write can commit on the first rising edge with rst=1.
- Reset mid-write: if rst falls in the same cycle as a pending write, the write is lost and all state reads as reset state.
- Committed write: on a rising clk edge with rst=1, rd_we=1 and rd_addr!=0:
  - reg[rd_addr] <= rd_wdata.
  - valid[rd_addr] <= 1.
  - wr_count increments.
- Register 0:
  - always reads 0 and never reports uninit.
  - writes to it are discarded and do not increment wr_count.
- Reads: combinational, zero latency from the address inputs.
  - Read result = reg[rsN_addr], or 0 when rsN_addr = 0.
- Bypass (BYPASS=1), applied when rd_we=1, rd_addr!=0 and rd_addr==rsN_addr:
  - rsN_data = rd_wdata in the same cycle.
  - rsN_uninit = 0.
- No bypass (BYPASS=0): read returns the pre-edge stored value; the new value is visible from the cycle after the edge.
- Both read ports may address the same register; each resolves independently and identically.
- rsN_uninit = ~valid[rsN_addr], subject to the bypass override above.
- wr_count saturates at 2**CNT_W-1; no wrap-around.
- Write with rd_we=0: no state change, regardless of rd_addr and rd_wdata.
- X/Z on rd_addr while rd_we=0 has no effect on state.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rs*_data = 0; uninit = 1 for addr 1..31, 0 for addr 0; wr_count = 0.
- Write 0xDEADBEEF to x5, then 0x00000010 to x6 on consecutive edges; read rs1=5, rs2=6 -> 0xDEADBEEF / 0x00000010; both uninit = 0; wr_count = 2.
- rd_we=1, rd_addr=0, rd_wdata=0xFFFFFFFF, then read rs1=0 -> 0; wr_count unchanged.
- BYPASS=1: rd_we=1, rd_addr=7, rd_wdata=0x12345678, rs1_addr=rs2_addr=7 in the same cycle, x7 never written -> both ports 0x12345678 and uninit = 0 before the edge.
- BYPASS=0: same stimulus -> both ports 0 and uninit = 1 before the edge; after the edge, 0x12345678 and uninit = 0.
- Write x3 = 0xA5A5A5A5; assert rst=0 between clock edges -> rs1_data (rs1=3) drops to 0 immediately; after rst=1, x3 reads 0, uninit = 1, wr_count = 0.
- CNT_W=2: perform 5 writes -> wr_count sequence 1, 2, 3, 3, 3 (saturates).
